// File: rtl/mips_prog_loader.sv
// Boot/run controller for pipe_MIPS32: streams a program into instruction memory,
// kicks the CPU with a one-cycle cpu_start pulse, then waits for HALTED under a watchdog.
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter int          TIMEOUT   = 1000,
  parameter logic [31:0] HLT_WORD  = 32'hfc000000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic [31:0]       run_cycles,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [31:0]     TIMEOUT_W = 32'(TIMEOUT);

  state_t      state;
  logic        xfer;
  logic [31:0] run_next;

  // Link handshake: a word moves on a rising edge where in_valid && in_ready are both high.
  // in_ready depends only on state, never on in_valid, and in_valid may drop at any time.
  assign in_ready  = (state == S_LOAD);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state == S_LOAD) || (state == S_START) || (state == S_RUN);
  assign run_next  = run_cycles + 32'd1;
  assign dbg_state = state;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_start    <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
      word_count   <= '0;
      checksum     <= '0;
      run_cycles   <= '0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (load_req) begin
            state        <= S_LOAD;
            word_count   <= '0;
            checksum     <= '0;
            run_cycles   <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= in_data;
            word_count <= word_count + (ADDR_W+1)'(1);
            checksum   <= checksum ^ in_data;
            // HLT takes priority so a program exactly MAX_WORDS long is still legal.
            if (in_data == HLT_WORD) begin
              state <= S_START;
            end else if (word_count == LAST_IDX) begin
              overflow_err <= 1'b1;
              done         <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_START: begin
          cpu_start <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          run_cycles <= run_next;
          // HALTED seen during the start pulse is left over from the previous run.
          if (!cpu_start && cpu_halted) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (run_next == TIMEOUT_W) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
